rr_arbiter: RTL



---
 rtl/rr_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin arbiter for WIDTH requesters with a rotating one-hot priority
//   pointer. The grant, its binary index and the valid flag are all registered,
//   so req and ack never reach the outputs combinationally.
//
//   With HOLD=1 a grant stays locked until the grantee acknowledges or drops
//   its request. With HOLD=0 arbitration happens again on every cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset; overrides every other input
//   req[W-1:0]   request vector, bit i belongs to requester i
//   ack          grantee done; releases the current grant (HOLD=1 only)
//   grant[W-1:0] registered one-hot grant, all-zero when idle
//   grant_valid  registered; high iff grant is non-zero
//   grant_idx    registered binary index of the granted bit, 0 when idle
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int IDX_W = $clog2(WIDTH),
  parameter bit HOLD  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] base_q,  base_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [WIDTH-1:0] win_s;
  logic             release_s;

  // Winner = first set bit of r at or above the one-hot base, wrapping round.
  // Replicating req makes the borrow of (x - base) run from base upward into
  // the upper copy, so x & ~(x - base) isolates exactly one bit; folding the
  // two halves back together gives the wrapped position.
  function automatic logic [WIDTH-1:0] arb_pick(input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] iso;
    dbl = {r, r};
    iso = dbl & ~(dbl - {{WIDTH{1'b0}}, b});
    return iso[WIDTH-1:0] | iso[2*WIDTH-1:WIDTH];
  endfunction

  // One-hot to binary; zero input yields zero.
  function automatic logic [IDX_W-1:0] to_idx(input logic [WIDTH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (oh[i]) begin
        idx = i[IDX_W-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  // Next-state, pointer and grant computation.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    grant_d   = grant_q;
    win_s     = '0;
    // The grant is released by an explicit ack or by the grantee going away.
    release_s = ack | ~(|(req & grant_q));
    if (HOLD) begin
      case (state_q)
        IDLE: begin
          win_s = arb_pick(req, base_q);
          if (|win_s) begin
            grant_d = win_s;
            state_d = BUSY;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (release_s) begin
            // Re-arbitrate in the same cycle against the rotated pointer so
            // a waiting requester is granted back-to-back.
            base_d = rotl1(grant_q);
            win_s  = arb_pick(req, base_d);
            if (|win_s) begin
              grant_d = win_s;
              state_d = BUSY;
            end else begin
              grant_d = '0;
              state_d = IDLE;
            end
          end else begin
            grant_d = grant_q;
            state_d = BUSY;
          end
        end
        default: begin
          grant_d = '0;
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = IDLE;
      win_s   = arb_pick(req, base_q);
      if (|win_s) begin
        grant_d = win_s;
        base_d  = rotl1(win_s);
      end else begin
        grant_d = '0;
      end
    end
    valid_d = |grant_d;
    idx_d   = to_idx(grant_d);
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

endmodule
